// File: rtl/axi4_burst_addr_seq.sv
// AXI4 burst address sequencer: takes one AW/AR-style command and emits one beat
// descriptor (address, index, last, strobe) per valid/ready handshake.
module axi4_burst_addr_seq #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [7:0]              cmd_len_i,
  input  logic [2:0]              cmd_size_i,
  input  logic [1:0]              cmd_burst_i,
  output logic                    beat_valid_o,
  input  logic                    beat_ready_i,
  output logic [ADDR_WIDTH-1:0]   beat_addr_o,
  output logic [7:0]              beat_idx_o,
  output logic                    beat_last_o,
  output logic [DATA_WIDTH/8-1:0] beat_strb_o,
  output logic                    err_o
);

  localparam int unsigned NB  = DATA_WIDTH / 8;
  localparam int unsigned LNB = $clog2(NB);

  localparam logic [1:0] BurstFixed = 2'd0;
  localparam logic [1:0] BurstIncr  = 2'd1;
  localparam logic [1:0] BurstWrap  = 2'd2;

  typedef enum logic {StIdle, StBurst} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            idx_q, idx_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  err_q, err_d;

  logic                  beat_valid;
  logic                  beat_last;
  logic                  beat_hs;
  logic                  cmd_acc;
  logic                  cmd_illegal;

  logic [ADDR_WIDTH-1:0] cmd_mask;
  logic [ADDR_WIDTH-1:0] cmd_end;
  logic                  size_bad;
  logic                  burst_bad;
  logic                  wrap_bad;
  logic                  cross_bad;

  logic [ADDR_WIDTH-1:0] cur_mask;
  logic [ADDR_WIDTH-1:0] cur_step;
  logic [ADDR_WIDTH-1:0] cur_al;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] addr_nxt;

  logic [ADDR_WIDTH-1:0] strb_lo;
  logic [ADDR_WIDTH-1:0] strb_hi;
  logic [NB-1:0]         strb;

  function automatic logic [ADDR_WIDTH-1:0] size_mask(input logic [2:0] size);
    return (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
  endfunction

  // Handshake and command acceptance
  always_comb begin
    beat_valid  = (state_q == StBurst);
    beat_last   = beat_valid && (idx_q == len_q);
    beat_hs     = beat_valid && beat_ready_i;
    cmd_ready_o = (state_q == StIdle) || (beat_hs && beat_last);
    cmd_acc     = cmd_valid_i && cmd_ready_o;
  end

  // Command legality; the 4KB check uses the aligned start plus len beats
  always_comb begin
    cmd_mask    = size_mask(cmd_size_i);
    cmd_end     = (cmd_addr_i & ~cmd_mask) + (ADDR_WIDTH'(cmd_len_i) << cmd_size_i);
    size_bad    = 32'(cmd_size_i) > LNB;
    burst_bad   = (cmd_burst_i == 2'd3);
    wrap_bad    = (cmd_burst_i == BurstWrap) &&
                  !(cmd_len_i inside {8'd1, 8'd3, 8'd7, 8'd15});
    cross_bad   = (cmd_burst_i == BurstIncr) &&
                  (cmd_addr_i[ADDR_WIDTH-1:12] != cmd_end[ADDR_WIDTH-1:12]);
    cmd_illegal = size_bad || burst_bad || wrap_bad || cross_bad;
  end

  // Address of the following beat
  always_comb begin
    cur_mask  = size_mask(size_q);
    cur_step  = ADDR_WIDTH'(1) << size_q;
    cur_al    = addr_q & ~cur_mask;
    wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    case (burst_q)
      BurstIncr: addr_nxt = cur_al + cur_step;
      BurstWrap: addr_nxt = (addr_q & ~wrap_mask) | ((cur_al + cur_step) & wrap_mask);
      default:   addr_nxt = addr_q;
    endcase
  end

  // Lanes from the current byte offset up to the end of the size-aligned beat
  always_comb begin
    strb_lo = addr_q & ADDR_WIDTH'(NB - 1);
    strb_hi = (addr_q | cur_mask) & ADDR_WIDTH'(NB - 1);
    for (int i = 0; i < NB; i++) begin
      strb[i] = (ADDR_WIDTH'(i) >= strb_lo) && (ADDR_WIDTH'(i) <= strb_hi);
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    err_d   = 1'b0;

    if (beat_hs) begin
      if (beat_last) begin
        state_d = StIdle;
        idx_d   = 8'd0;
      end else begin
        addr_d = addr_nxt;
        idx_d  = idx_q + 8'd1;
      end
    end

    // A command accepted on the last handshake overrides the return to idle
    if (cmd_acc) begin
      if (cmd_illegal) begin
        err_d   = 1'b1;
        state_d = StIdle;
        idx_d   = 8'd0;
      end else begin
        state_d = StBurst;
        addr_d  = cmd_addr_i;
        idx_d   = 8'd0;
        len_d   = cmd_len_i;
        size_d  = cmd_size_i;
        burst_d = cmd_burst_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= BurstFixed;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      err_q   <= err_d;
    end
  end

  assign beat_valid_o = beat_valid;
  assign beat_addr_o  = addr_q;
  assign beat_idx_o   = idx_q;
  assign beat_last_o  = beat_last;
  assign beat_strb_o  = beat_valid ? strb : '0;
  assign err_o        = err_q;

endmodule
